byte_unstriping: RTL and testbench
==================================

// Module: byte_unstriping
// PURPOSE
//   Receive-side inverse of the byte striper. Takes the two striped 8-bit lanes
//   (even bytes on lane 0, odd bytes on lane 1) and rebuilds the original
//   single byte stream in order, one byte per clk_2f cycle.
//   Each lane has a small FIFO to absorb lane skew. A round-robin selector
//   reads from lane 0, then lane 1, and so on.
// PARAMETERS
//   DEPTH  4  entries per lane FIFO (power of 2, >=2)
//   AW     2  FIFO pointer width, log2(DEPTH)
// PORTS
//   clk_2f      in   1  single clock; all logic on its rising edge
//   reset       in   1  asynchronous, active-low reset
//   lane_0      in   8  lane 0 byte (even positions of the stream)
//   valid_0     in   1  lane_0 carries a byte this cycle
//   lane_1      in   8  lane 1 byte (odd positions of the stream)
//   valid_1     in   1  lane_1 carries a byte this cycle
//   data_out    out  8  rebuilt byte stream
//   valid_out   out  1  data_out valid this cycle
//   ready_0     out  1  lane 0 FIFO not full (advisory)
//   ready_1     out  1  lane 1 FIFO not full (advisory)
//   overflow_0  out  1  sticky: a lane 0 byte was dropped
//   overflow_1  out  1  sticky: a lane 1 byte was dropped
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): FIFOs emptied, counts=0, sel=0;
//     data_out=8'h00, valid_out=0, overflow_*=0, ready_*=1.
//   - Each lane FIFO has wr_ptr, rd_ptr (AW bits, wrap mod DEPTH) and
//     count (AW+1 bits, 0..DEPTH).
//   - Write: valid_x=1 and FIFO not full -> store lane_x, wr_ptr++.
//   - Full-write rule:
//     - valid_x=1 with count==DEPTH and no read of that lane this cycle ->
//       byte dropped and overflow_x set.
//     - If the same lane is read in that cycle, the write is accepted and
//       count stays DEPTH.
//   - Selector state sel (1 bit): LANE0 / LANE1.
//     - In state sel, if FIFO[sel] is not empty: pop one byte, register it on
//       data_out with valid_out=1 next cycle, toggle sel.
//     - If FIFO[sel] is empty: no pop, valid_out=0 next cycle, data_out=8'h00,
//       sel unchanged.
//     - The other lane is never read out of turn, even when it holds data.
//       This preserves byte order.
//   - Latency: a byte written at edge N can appear on data_out at edge N+1 at
//     the earliest. The FIFO read is combinational from the stored entry; the
//     output register is the single pipeline stage.
//   - Throughput: at most 1 byte/cycle out; up to 2 bytes/cycle in (both lanes).
//   - A simultaneous write and read on the same FIFO is legal in every state:
//     - empty FIFO: the new byte is not readable until the next cycle;
//     - full FIFO: see the full-write rule above.
//   - ready_x = (count_x != DEPTH), combinational from the registered count.
//   - overflow_x clears only on reset. After an overflow the stream order is
//     corrupt; no recovery is attempted.
//   - Reset asserted mid-stream: all buffered bytes are discarded immediately;
//     after release, the first lane 0 byte is output first again.
// TESTING
//   1 In order: lane_0=FF@c1, lane_1=EE@c2, lane_0=DD@c3, lane_1=CC@c4 ->
//     data_out FF,EE,DD,CC with valid_out=1 at c2..c5.
//   2 Skew: lane_1=EE@c1, lane_0=FF@c3 -> valid_out=0 through c3;
//     FF@c4, EE@c5.
//   3 Same-cycle lanes: valid_0=valid_1=1 with 03/04@c1, then 07/08@c2 ->
//     03,04,07,08 on consecutive cycles c2..c5; ready_*=1 throughout.
//   4 Overflow: 5 lane_1 writes (11..15) with lane 0 idle ->
//     - ready_1=0 after 4th write;
//     - overflow_1=1 after 5th write, byte 15 dropped;
//     - then lane_0=AA -> output AA,11.
//   5 Reset mid-run: load 3 bytes per lane, pull reset low for 1 cycle ->
//     - outputs and overflow flags 0 immediately;
//     - next lane_0=5A, lane_1=A5 -> output 5A then A5.
//   6 Idle/invalid: valid_0=valid_1=0 with random lane data for 8 cycles ->
//     valid_out=0 and data_out=8'h00 throughout.

Source files
------------

// File: rtl/byte_unstriping_if.sv
// Lane inputs and rebuilt-stream outputs of the byte unstriper.
// master drives the lanes; slave is the unstriper itself.
interface byte_unstriping_if;
    logic [7:0] lane_0;
    logic       valid_0;
    logic [7:0] lane_1;
    logic       valid_1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_0;
    logic       ready_1;
    logic       overflow_0;
    logic       overflow_1;

    modport master (
        output lane_0, valid_0, lane_1, valid_1,
        input  data_out, valid_out, ready_0, ready_1, overflow_0, overflow_1
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1,
        output data_out, valid_out, ready_0, ready_1, overflow_0, overflow_1
    );
endinterface

// File: rtl/byte_unstriping.sv
// Rebuilds one byte stream from two striped lanes (even bytes on lane 0, odd on lane 1).
// Each lane buffers skew in a small FIFO; a strict round-robin reader preserves order.
module byte_unstriping #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input logic               clk_2f,
    input logic               reset,
    byte_unstriping_if.slave  bus
);

    localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

    logic [7:0]    lane_in  [2];
    logic [1:0]    lane_vld;

    logic [7:0]    mem_q    [2][DEPTH];
    logic [7:0]    mem_d    [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [AW:0]   count_q  [2];
    logic [AW:0]   count_d  [2];
    logic [1:0]    ovf_q, ovf_d;
    logic [1:0]    full, empty, rd_en, wr_en;
    logic          pop;
    logic          sel_q, sel_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    assign lane_in[0]  = bus.lane_0;
    assign lane_in[1]  = bus.lane_1;
    assign lane_vld[0] = bus.valid_0;
    assign lane_vld[1] = bus.valid_1;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        full     = '0;
        empty    = '0;
        wr_en    = '0;

        for (int l = 0; l < 2; l++) begin
            full[l]  = (count_q[l] == CountFull);
            empty[l] = (count_q[l] == '0);
        end

        // Only the lane whose turn it is may be read; the other waits even if it has data.
        pop      = !empty[sel_q];
        rd_en[0] = pop && !sel_q;
        rd_en[1] = pop && sel_q;

        for (int l = 0; l < 2; l++) begin
            // A read in the same cycle frees a slot, so a full FIFO still accepts.
            wr_en[l] = lane_vld[l] && (!full[l] || rd_en[l]);
            if (lane_vld[l] && full[l] && !rd_en[l]) begin
                ovf_d[l] = 1'b1;
            end
            if (wr_en[l]) begin
                mem_d[l][wr_ptr_q[l]] = lane_in[l];
                wr_ptr_d[l]           = wr_ptr_q[l] + 1'b1;
            end
            if (rd_en[l]) begin
                rd_ptr_d[l] = rd_ptr_q[l] + 1'b1;
            end
            count_d[l] = count_q[l] + (AW + 1)'(wr_en[l]) - (AW + 1)'(rd_en[l]);
        end

        if (pop) begin
            data_d  = mem_q[sel_q][rd_ptr_q[sel_q]];
            valid_d = 1'b1;
            sel_d   = ~sel_q;
        end else begin
            data_d  = 8'h00;
            valid_d = 1'b0;
            sel_d   = sel_q;
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < 2; l++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[l][i] <= 8'h00;
                end
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                count_q[l]  <= '0;
            end
            ovf_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.ready_0    = !full[0];
    assign bus.ready_1    = !full[1];
    assign bus.overflow_0 = ovf_q[0];
    assign bus.overflow_1 = ovf_q[1];

endmodule

// File: tb/tb_byte_unstriping.sv
// Bench for byte_unstriping: directed scenarios plus random lane traffic,
// compared cycle by cycle against a queue-based model of the two lanes.
module tb_byte_unstriping;

    localparam int unsigned DEPTH = 4;

    logic clk_2f = 1'b0;
    logic reset  = 1'b0;
    always #5 clk_2f = ~clk_2f;

    byte_unstriping_if bus ();

    byte_unstriping #(
        .DEPTH (DEPTH),
        .AW    (2)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Reference model: one queue per lane, whose turn it is, sticky drop flags.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         turn;
    bit         drop0, drop1;
    logic [7:0] exp_data;
    bit         exp_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h expected %0h (t=%0t)", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        turn      = 1'b0;
        drop0     = 1'b0;
        drop1     = 1'b0;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
    endtask

    task automatic model_step(input bit v0, input logic [7:0] d0, input bit v1,
                              input logic [7:0] d1);
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        if (!turn && q0.size() > 0) begin
            exp_data  = q0.pop_front();
            exp_valid = 1'b1;
            turn      = 1'b1;
        end else if (turn && q1.size() > 0) begin
            exp_data  = q1.pop_front();
            exp_valid = 1'b1;
            turn      = 1'b0;
        end
        // Bytes arriving this cycle cannot be read until the next one.
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else drop0 = 1'b1;
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else drop1 = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_eq("data_out",   32'(bus.data_out),   32'(exp_data));
        check_eq("valid_out",  32'(bus.valid_out),  32'(exp_valid));
        check_eq("ready_0",    32'(bus.ready_0),    32'(q0.size() != DEPTH));
        check_eq("ready_1",    32'(bus.ready_1),    32'(q1.size() != DEPTH));
        check_eq("overflow_0", 32'(bus.overflow_0), 32'(drop0));
        check_eq("overflow_1", 32'(bus.overflow_1), 32'(drop1));
    endtask

    // Drive one cycle of lane inputs, then check what the edge produced.
    task automatic cycle(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        bus.valid_0 = v0;
        bus.lane_0  = d0;
        bus.valid_1 = v1;
        bus.lane_1  = d1;
        model_step(v0, d0, v1, d1);
        @(posedge clk_2f);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Assert reset between edges so its effect must be asynchronous.
    task automatic do_reset();
        @(negedge clk_2f);
        bus.valid_0 = 1'b0;
        bus.valid_1 = 1'b0;
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs();
        @(negedge clk_2f);
        reset = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.lane_0  = 8'h00;
        bus.valid_0 = 1'b0;
        bus.lane_1  = 8'h00;
        bus.valid_1 = 1'b0;
        model_clear();

        phase = "reset";
        #2;
        check_outputs();
        @(negedge clk_2f);
        reset = 1'b1;

        phase = "in_order";
        cycle(1'b1, 8'hFF, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 8'hEE);
        cycle(1'b1, 8'hDD, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 8'hCC);
        idle(3);

        phase = "skew";
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 8'hEE);
        cycle(1'b0, 8'h00, 1'b0, 8'h00);
        cycle(1'b1, 8'hFF, 1'b0, 8'h00);
        idle(3);

        phase = "same_cycle";
        do_reset();
        cycle(1'b1, 8'h03, 1'b1, 8'h04);
        cycle(1'b1, 8'h07, 1'b1, 8'h08);
        idle(5);

        phase = "overflow";
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 8'(8'h11 + i));
        cycle(1'b1, 8'hAA, 1'b0, 8'h00);
        idle(4);

        phase = "reset_mid";
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h21 + 2 * i), 1'b1, 8'(8'h22 + 2 * i));
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0, 8'h00);
        cycle(1'b0, 8'h00, 1'b1, 8'hA5);
        idle(3);

        phase = "idle";
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'($urandom), 1'b0, 8'($urandom));

        // Random traffic at light, medium and saturating load.
        for (int b = 0; b < 3; b++) begin
            int pct;
            pct   = (b == 0) ? 30 : (b == 1) ? 55 : 90;
            phase = $sformatf("random%0d", b);
            do_reset();
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < pct, 8'($urandom),
                      $urandom_range(0, 99) < pct, 8'($urandom));
            end
            idle(10);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
